// File: rtl/lsu.sv
// Load-store unit: decodes the ALU byte address into data memory, output
// peripheral registers and the switch input. Stores are word-wide and happen
// on the rising edge; loads are purely combinational.
module lsu #(
   parameter int DMEM_WORDS = 2048
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        st_en,
   input  logic [31:0] addr,
   input  logic [31:0] st_data,
   input  logic [31:0] io_sw,
   output logic [31:0] ld_data,
   output logic [31:0] io_hex0,
   output logic [31:0] io_hex1,
   output logic [31:0] io_hex2,
   output logic [31:0] io_hex3,
   output logic [31:0] io_hex4,
   output logic [31:0] io_hex5,
   output logic [31:0] io_hex6,
   output logic [31:0] io_hex7,
   output logic [31:0] io_ledg,
   output logic [31:0] io_ledr,
   output logic [31:0] io_lcd
);

   localparam int          AW        = $clog2(DMEM_WORDS);
   localparam logic [31:0] DMEM_BASE = 32'h0000_2000;
   localparam logic [31:0] DMEM_END  = DMEM_BASE + 32'(DMEM_WORDS * 4);

   // Word addresses (byte address >> 2) of the peripherals.
   localparam logic [29:0] WA_LEDR   = 30'h0000_1C00;  // 0x7000
   localparam logic [29:0] WA_LEDG   = 30'h0000_1C04;  // 0x7010
   localparam logic [26:0] WA_HEXGRP = 27'h000_0381;   // 0x7020..0x703C, index in wa[2:0]
   localparam logic [29:0] WA_LCD    = 30'h0000_1C10;  // 0x7040
   localparam logic [29:0] WA_SW     = 30'h0000_1E00;  // 0x7800

   logic [31:0] mem [DMEM_WORDS];
   logic [31:0] hex_q [8];
   logic [31:0] ledg_q;
   logic [31:0] ledr_q;
   logic [31:0] lcd_q;

   logic [29:0]   wa;
   logic          dmem_sel;
   logic          hex_sel;
   logic [AW-1:0] dmem_idx;

   assign wa       = addr[31:2];
   // Full 32-bit range check, so aliases such as 0x0001_2000 stay unmapped.
   assign dmem_sel = (addr >= DMEM_BASE) && (addr < DMEM_END);
   assign hex_sel  = (wa[29:3] == WA_HEXGRP);
   // The base is aligned to the memory size, so the low address bits index directly.
   assign dmem_idx = addr[AW+1:2];

   // Data memory write port; reset blocks the store but never clears contents.
   always_ff @(posedge clk_i) begin
      if (!rst_ni && st_en && dmem_sel) begin
         mem[dmem_idx] <= st_data;
      end
   end

   // Peripheral registers: cleared by reset, otherwise updated by a decoded store.
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         for (int i = 0; i < 8; i++) hex_q[i] <= '0;
         ledg_q <= '0;
         ledr_q <= '0;
         lcd_q  <= '0;
      end else if (st_en) begin
         if (hex_sel)          hex_q[wa[2:0]] <= st_data;
         if (wa == WA_LEDG)    ledg_q <= st_data;
         if (wa == WA_LEDR)    ledr_q <= st_data;
         if (wa == WA_LCD)     lcd_q  <= st_data;
      end
   end

   // Combinational load mux; anything unmapped reads as zero.
   always_comb begin
      ld_data = '0;
      if (dmem_sel) begin
         ld_data = mem[dmem_idx];
      end else if (hex_sel) begin
         ld_data = hex_q[wa[2:0]];
      end else begin
         case (wa)
            WA_LEDR: ld_data = ledr_q;
            WA_LEDG: ld_data = ledg_q;
            WA_LCD:  ld_data = lcd_q;
            WA_SW:   ld_data = io_sw;
            default: ld_data = '0;
         endcase
      end
   end

   assign io_hex0 = hex_q[0];
   assign io_hex1 = hex_q[1];
   assign io_hex2 = hex_q[2];
   assign io_hex3 = hex_q[3];
   assign io_hex4 = hex_q[4];
   assign io_hex5 = hex_q[5];
   assign io_hex6 = hex_q[6];
   assign io_hex7 = hex_q[7];
   assign io_ledg = ledg_q;
   assign io_ledr = ledr_q;
   assign io_lcd  = lcd_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load-store unit.
module tb_lsu;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        st_en;
   logic [31:0] addr;
   logic [31:0] st_data;
   logic [31:0] io_sw;
   logic [31:0] ld_data;
   logic [31:0] io_hex0, io_hex1, io_hex2, io_hex3;
   logic [31:0] io_hex4, io_hex5, io_hex6, io_hex7;
   logic [31:0] io_ledg, io_ledr, io_lcd;

   int total = 0;
   int bad   = 0;

   lsu #(.DMEM_WORDS(2048)) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .st_en   (st_en),
      .addr    (addr),
      .st_data (st_data),
      .io_sw   (io_sw),
      .ld_data (ld_data),
      .io_hex0 (io_hex0),
      .io_hex1 (io_hex1),
      .io_hex2 (io_hex2),
      .io_hex3 (io_hex3),
      .io_hex4 (io_hex4),
      .io_hex5 (io_hex5),
      .io_hex6 (io_hex6),
      .io_hex7 (io_hex7),
      .io_ledg (io_ledg),
      .io_ledr (io_ledr),
      .io_lcd  (io_lcd)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One rising edge, then settle 1ns past it.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      addr    = a;
      st_data = d;
      st_en   = 1'b1;
      tick();
      st_en   = 1'b0;
   endtask

   task automatic load(input string tag, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      chk(tag, ld_data, exp);
   endtask

   task automatic do_reset();
      rst_ni = 1'b1;
      tick();
      rst_ni = 1'b0;
   endtask

   initial begin
      rst_ni  = 1'b1;
      st_en   = 1'b0;
      addr    = '0;
      st_data = '0;
      io_sw   = '0;

      // Reset clears every output register.
      tick();
      rst_ni = 1'b0;
      chk("rst_hex0", io_hex0, 32'h0);
      chk("rst_hex1", io_hex1, 32'h0);
      chk("rst_hex2", io_hex2, 32'h0);
      chk("rst_hex3", io_hex3, 32'h0);
      chk("rst_hex4", io_hex4, 32'h0);
      chk("rst_hex5", io_hex5, 32'h0);
      chk("rst_hex6", io_hex6, 32'h0);
      chk("rst_hex7", io_hex7, 32'h0);
      chk("rst_ledg", io_ledg, 32'h0);
      chk("rst_ledr", io_ledr, 32'h0);
      chk("rst_lcd",  io_lcd,  32'h0);

      // Memory store visible right after the edge.
      store(32'h3000, 32'h8);
      chk("mem_3000", ld_data, 32'h8);
      store(32'h3FFC, 32'hCAFE_F00D);
      chk("mem_top", ld_data, 32'hCAFE_F00D);
      load("mem_past_end", 32'h4000, 32'h0);
      load("mem_3000_again", 32'h3000, 32'h8);

      // Peripheral stores and readback.
      store(32'h7020, 32'h8);
      store(32'h7040, 32'hA5);
      chk("hex0", io_hex0, 32'h8);
      chk("lcd", io_lcd, 32'hA5);
      load("rd_hex0", 32'h7020, 32'h8);
      load("rd_lcd", 32'h7040, 32'hA5);
      store(32'h7034, 32'h55);
      chk("hex5", io_hex5, 32'h55);
      chk("hex4_untouched", io_hex4, 32'h0);
      load("rd_hex5_unaligned", 32'h7036, 32'h55);
      store(32'h703C, 32'h77);
      chk("hex7", io_hex7, 32'h77);
      store(32'h7000, 32'h11);
      chk("ledr", io_ledr, 32'h11);
      load("rd_ledr", 32'h7000, 32'h11);
      store(32'h7010, 32'h22);
      chk("ledg", io_ledg, 32'h22);
      load("rd_ledg", 32'h7010, 32'h22);
      do_reset();
      chk("hex0_after_rst", io_hex0, 32'h0);
      chk("lcd_after_rst", io_lcd, 32'h0);
      chk("hex5_after_rst", io_hex5, 32'h0);
      chk("ledr_after_rst", io_ledr, 32'h0);
      chk("ledg_after_rst", io_ledg, 32'h0);

      // Switch input is read-only.
      io_sw = 32'h1234;
      load("sw_read", 32'h7800, 32'h1234);
      store(32'h7800, 32'hFFFF);
      load("sw_after_store", 32'h7800, 32'h1234);
      io_sw = 32'hABCD_0001;
      load("sw_follows_input", 32'h7800, 32'hABCD_0001);

      // Memory survives reset; unmapped and aliased addresses read zero.
      store(32'h2000, 32'hDEAD);
      do_reset();
      load("mem_kept", 32'h2000, 32'hDEAD);
      load("unmapped_5000", 32'h5000, 32'h0);
      store(32'h0001_2000, 32'hBEEF);
      load("no_alias_rd", 32'h0001_2000, 32'h0);
      load("no_alias_mem", 32'h2000, 32'hDEAD);
      load("unmapped_1ffc", 32'h1FFC, 32'h0);

      // Reset wins over a store on the same edge.
      store(32'h2004, 32'h5);
      rst_ni  = 1'b1;
      st_en   = 1'b1;
      addr    = 32'h7010;
      st_data = 32'h99;
      tick();
      chk("ledg_rst_wins", io_ledg, 32'h0);
      addr    = 32'h2004;
      st_data = 32'h9;
      tick();
      rst_ni = 1'b0;
      st_en  = 1'b0;
      load("mem_rst_wins", 32'h2004, 32'h5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
